cpu_controller: RTL and testbench

//  8-phase instruction sequencer for the 8-bit accumulator CPU. Drives the opcode-side control strobes
//  (address mux, memory rd/wr, IR/AC/PC loads, PC increment, data bus enable, halt).

---
 rtl/cpu_controller.sv | 149 ++++++++++++++
 tb/tb_cpu_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer driving the accumulator CPU's control strobes.
// Optional single-step control is compiled in when CPU_CTRL_SINGLE_STEP_EN is defined.
`ifndef OPCODE_HLT
`define OPCODE_HLT 3'd0
`define OPCODE_SKZ 3'd1
`define OPCODE_ADD 3'd2
`define OPCODE_AND 3'd3
`define OPCODE_XOR 3'd4
`define OPCODE_LDA 3'd5
`define OPCODE_STO 3'd6
`define OPCODE_JMP 3'd7
`endif

module cpu_controller #(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic           step_en,
  input  logic           step,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           wr,
  output logic           data_e,
  output logic           halt,
  output logic [2:0]     phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t phase_q, phase_d;
  logic   sel_d, rd_d, ld_ir_d, inc_pc_d, ld_pc_d, ld_ac_d, wr_d, data_e_d, halt_d;
  logic   hold;
  logic   is_aluop, is_hlt, is_skz, is_sto, is_jmp;

  assign is_aluop = (opcode == OPW'(`OPCODE_ADD)) || (opcode == OPW'(`OPCODE_AND)) ||
                    (opcode == OPW'(`OPCODE_XOR)) || (opcode == OPW'(`OPCODE_LDA));
  assign is_hlt   = (opcode == OPW'(`OPCODE_HLT));
  assign is_skz   = (opcode == OPW'(`OPCODE_SKZ));
  assign is_sto   = (opcode == OPW'(`OPCODE_STO));
  assign is_jmp   = (opcode == OPW'(`OPCODE_JMP));

  // Strobes are decoded for the phase about to be entered, so after the register
  // stage they line up with the cycle in which the counter shows that phase.
  always_comb begin
    phase_d  = phase_q;
    sel_d    = 1'b0;
    rd_d     = 1'b0;
    ld_ir_d  = 1'b0;
    inc_pc_d = 1'b0;
    ld_pc_d  = 1'b0;
    ld_ac_d  = 1'b0;
    wr_d     = 1'b0;
    data_e_d = 1'b0;
    halt_d   = halt;
    hold     = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    hold     = step_en && (phase_q == INST_ADDR) && !step;
`endif
    if (!halt) begin
      if (!hold) begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
      case (phase_d)
        INST_ADDR: begin
          sel_d = 1'b1;
        end
        INST_FETCH: begin
          sel_d = 1'b1;
          rd_d  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel_d   = 1'b1;
          rd_d    = 1'b1;
          ld_ir_d = 1'b1;
        end
        OP_ADDR: begin
          inc_pc_d = 1'b1;
          halt_d   = is_hlt;
        end
        OP_FETCH: begin
          rd_d = is_aluop;
        end
        // zero only matters here; SKZ skips the next instruction by a second PC increment.
        ALU_OP: begin
          rd_d     = is_aluop;
          inc_pc_d = is_skz && zero;
          ld_pc_d  = is_jmp;
          data_e_d = is_sto;
        end
        STORE: begin
          rd_d     = is_aluop;
          ld_ac_d  = is_aluop;
          ld_pc_d  = is_jmp;
          inc_pc_d = is_jmp;
          wr_d     = is_sto;
          data_e_d = is_sto;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= INST_ADDR;
      sel     <= 1'b1;
      rd      <= 1'b0;
      ld_ir   <= 1'b0;
      inc_pc  <= 1'b0;
      ld_pc   <= 1'b0;
      ld_ac   <= 1'b0;
      wr      <= 1'b0;
      data_e  <= 1'b0;
      halt    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sel     <= sel_d;
      rd      <= rd_d;
      ld_ir   <= ld_ir_d;
      inc_pc  <= inc_pc_d;
      ld_pc   <= ld_pc_d;
      ld_ac   <= ld_ac_d;
      wr      <= wr_d;
      data_e  <= data_e_d;
      halt    <= halt_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: randomized scoreboard bench for cpu_controller.
// Expected strobes come from per-opcode phase masks; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cpu_controller;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_OP = 3'd3,
                         XOR_OP = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic       step_en = 1'b0;
  logic       step = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] ph;
    logic [8:0] strb;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_controller #(.OPW(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step_en(step_en),
    .step(step),
`endif
    .opcode(opcode),
    .zero(zero),
    .sel(sel),
    .rd(rd),
    .ld_ir(ld_ir),
    .inc_pc(inc_pc),
    .ld_pc(ld_pc),
    .ld_ac(ld_ac),
    .wr(wr),
    .data_e(data_e),
    .halt(halt),
    .phase(phase)
  );

  // Reference: each strobe is a bit mask over phases 0..7, chosen by opcode.
  function automatic logic [8:0] model(input logic [2:0] opc, input logic z, input logic [2:0] ph);
    logic       alu;
    logic [7:0] m_sel, m_rd, m_ir, m_inc, m_ldpc, m_ldac, m_wr, m_de, m_halt;
    alu    = (opc == ADD) || (opc == AND_OP) || (opc == XOR_OP) || (opc == LDA);
    m_sel  = 8'b0000_1111;
    m_rd   = alu ? 8'b1110_1110 : 8'b0000_1110;
    m_ir   = 8'b0000_1100;
    m_inc  = 8'b0001_0000 | ((opc == SKZ && z) ? 8'b0100_0000 : 8'h00)
                          | ((opc == JMP) ? 8'b1000_0000 : 8'h00);
    m_ldpc = (opc == JMP) ? 8'b1100_0000 : 8'h00;
    m_ldac = alu ? 8'b1000_0000 : 8'h00;
    m_wr   = (opc == STO) ? 8'b1000_0000 : 8'h00;
    m_de   = (opc == STO) ? 8'b1100_0000 : 8'h00;
    m_halt = (opc == HLT) ? 8'b0001_0000 : 8'h00;
    return {m_sel[ph], m_rd[ph], m_ir[ph], m_inc[ph], m_ldpc[ph],
            m_ldac[ph], m_wr[ph], m_de[ph], m_halt[ph]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      e = expq.pop_front();
      check_output("phase", 32'(phase), 32'(e.ph));
      check_output("strobes", 32'({sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}), 32'(e.strb));
      check_output("excl", 32'({rd & wr, wr & ld_ir}), 32'd0);
    end
  end

  // Called with phase 0 visible; pushes n_push expected cycles, then waits n_wait edges.
  task automatic apply_stimulus(input logic [2:0] opc, input logic z, input int n_push, input int n_wait);
    exp_t r;
    opcode = opc;
    zero   = z;
    for (int k = 0; k < n_push; k++) begin
      if (opc == HLT && k > 4) begin
        r.ph   = 3'd4;
        r.strb = 9'b0_0000_0001;
      end else begin
        r.ph   = 3'(k % 8);
        r.strb = model(opc, z, 3'(k % 8));
      end
      expq.push_back(r);
    end
    repeat (n_wait) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0] ropc;
    logic       rz;
    reset_dut();
    apply_stimulus(ADD, 1'b0, 6, 5);
    reset_dut();
    apply_stimulus(ADD, 1'b0, 8, 8);
    apply_stimulus(SKZ, 1'b1, 8, 8);
    apply_stimulus(SKZ, 1'b0, 8, 8);
    apply_stimulus(STO, 1'b1, 8, 8);
    apply_stimulus(JMP, 1'b0, 8, 8);
    for (int i = 0; i < 40; i++) begin
      ropc = 3'($urandom_range(1, 7));
      rz   = 1'($urandom_range(0, 1));
      apply_stimulus(ropc, rz, 8, 8);
    end
    apply_stimulus(HLT, 1'b0, 25, 25);
    reset_dut();
    apply_stimulus(LDA, 1'b1, 8, 8);
`ifdef CPU_CTRL_SINGLE_STEP_EN
    step_en = 1'b1;
    step    = 1'b0;
    apply_stimulus(ADD, 1'b0, 1, 0);
    expq.push_back('{ph: 3'd0, strb: model(ADD, 1'b0, 3'd0)});
    expq.push_back('{ph: 3'd0, strb: model(ADD, 1'b0, 3'd0)});
    repeat (3) @(posedge clk);
    #1;
    step = 1'b1;
    apply_stimulus(XOR_OP, 1'b0, 8, 1);
    step = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) expq.push_back('{ph: 3'd0, strb: model(XOR_OP, 1'b0, 3'd0)});
    repeat (4) @(posedge clk);
    #1;
    step_en = 1'b0;
    apply_stimulus(AND_OP, 1'b0, 8, 8);
`endif
    @(posedge clk);
    #1;
    check_output("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
